// File: rtl/helen_nios_cpu_ocimem_arbiter.sv
// Shares the single-port Nios debug OCI RAM between the JTAG debug-slave and the Avalon debug_mem port.
// Build option: define HELEN_OCIMEM_JTAG_PRIO_EN for fixed JTAG priority; round-robin otherwise.
module helen_nios_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jtag_addr_load,
    input  logic [ADDR_W-1:0]     jtag_addr_in,
    input  logic                  jtag_req,
    input  logic                  jtag_wr,
    input  logic [DATA_W-1:0]     jtag_wdata,
    output logic [DATA_W-1:0]     jtag_rdata,
    output logic                  jtag_done,
    output logic                  jtag_busy,
    output logic                  jtag_overrun,
    input  logic                  jtag_overrun_clr,
    input  logic [ADDR_W-1:0]     avm_address,
    input  logic                  avm_read,
    input  logic                  avm_write,
    input  logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W/8-1:0]   avm_byteenable,
    output logic [DATA_W-1:0]     avm_readdata,
    output logic                  avm_waitrequest,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_we,
    input  logic [DATA_W-1:0]     ram_rdata
);

    // state   | meaning
    // IDLE    | no access in flight; arbitrate and launch the next one
    // ACCESS  | address/data on the RAM; writes commit here
    // RDATA   | ram_rdata valid for the read issued in ACCESS
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDATA  = 2'd2;

    localparam logic OWN_AVM  = 1'b0;
    localparam logic OWN_JTAG = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic [ADDR_W-1:0] jtag_ptr;
    logic              jtag_pend;
    logic              jtag_cmd_wr;
    logic [DATA_W-1:0] jtag_cmd_wdata;
    logic              avm_req;
    logic              grant_jtag;
    logic              access_end;
    logic              jtag_complete;

    assign avm_req       = avm_read | avm_write;
    // An access finishes in ACCESS for writes and in RDATA for reads.
    assign access_end    = (state == ST_ACCESS && ram_we) || (state == ST_RDATA);
    assign jtag_complete = (owner == OWN_JTAG) && access_end;

    assign jtag_busy       = jtag_pend | ((owner == OWN_JTAG) && (state != ST_IDLE));
    assign avm_waitrequest = !((owner == OWN_AVM) && access_end);
    assign avm_readdata    = ((owner == OWN_AVM) && (state == ST_RDATA)) ? ram_rdata : '0;

`ifdef HELEN_OCIMEM_JTAG_PRIO_EN
    always_comb begin
        grant_jtag = jtag_pend;
    end
`else
    logic last_grant;

    always_comb begin
        grant_jtag = jtag_pend;
        if (jtag_pend && avm_req) begin
            grant_jtag = (last_grant == OWN_AVM);
        end
    end

    // last_grant only moves on a genuine conflict so uncontested accesses don't skew fairness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= OWN_AVM;
        end else if (state == ST_IDLE && jtag_pend && avm_req) begin
            last_grant <= grant_jtag;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_AVM;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
            ram_we    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (jtag_pend || avm_req) begin
                        state <= ST_ACCESS;
                        owner <= grant_jtag;
                        if (grant_jtag) begin
                            ram_addr  <= jtag_ptr;
                            ram_wdata <= jtag_cmd_wdata;
                            ram_be    <= '1;
                            ram_we    <= jtag_cmd_wr;
                        end else begin
                            ram_addr  <= avm_address;
                            ram_wdata <= avm_writedata;
                            ram_be    <= avm_byteenable;
                            ram_we    <= avm_write;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ram_we) begin
                        ram_we <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jtag_ptr       <= '0;
            jtag_pend      <= 1'b0;
            jtag_cmd_wr    <= 1'b0;
            jtag_cmd_wdata <= '0;
            jtag_rdata     <= '0;
            jtag_done      <= 1'b0;
            jtag_overrun   <= 1'b0;
        end else begin
            jtag_done <= jtag_complete;
            if (jtag_complete) begin
                jtag_pend <= 1'b0;
                jtag_ptr  <= jtag_ptr + ADDR_W'(1);
                if (state == ST_RDATA) begin
                    jtag_rdata <= ram_rdata;
                end
            end
            if (jtag_req && !jtag_busy) begin
                jtag_pend      <= 1'b1;
                jtag_cmd_wr    <= jtag_wr;
                jtag_cmd_wdata <= jtag_wdata;
            end
            if (jtag_addr_load && !jtag_busy) begin
                jtag_ptr <= jtag_addr_in;
            end
            if (jtag_req && jtag_busy) begin
                jtag_overrun <= 1'b1;
            end else if (jtag_overrun_clr) begin
                jtag_overrun <= 1'b0;
            end
        end
    end

endmodule
